// File: rtl/signed_result_to_bcd_pkg.sv
// Shared calculator datapath constants and the converter state encoding.
package signed_result_to_bcd_pkg;

   localparam int unsigned CALC_WIDTH      = 8;
   localparam int unsigned CALC_BCD_DIGITS = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CONV = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/signed_result_to_bcd_digit_adjust.sv
// One double-dabble correction step: a BCD digit of 5 or more gets 3 added before the shift.
module bcd_digit_adjust (
   input  logic [3:0] i_digit,
   output logic [3:0] o_digit
);

   always_comb begin
      o_digit = i_digit;
      if (i_digit >= 4'd5) begin
         o_digit = i_digit + 4'd3;
      end
   end

endmodule

// File: rtl/signed_result_to_bcd.sv
// Captures a signed multiplier product and converts it to sign + packed BCD
// with a serial double-dabble, one bit per cycle.
module signed_result_to_bcd
   import signed_result_to_bcd_pkg::*;
#(
   parameter int unsigned WIDTH  = CALC_WIDTH,
   parameter int unsigned DIGITS = CALC_BCD_DIGITS
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [WIDTH-1:0]      din,
   input  logic                  din_valid,
   output logic                  busy,
   output logic                  sign,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  dout_valid,
   output logic                  dropped
);

   localparam int unsigned ITER_W = $clog2(WIDTH + 1);
   localparam int unsigned CAT_W  = 4*DIGITS + WIDTH;

   state_t                r_state;
   logic [ITER_W-1:0]     r_iter;
   logic [WIDTH-1:0]      r_mag;
   logic [4*DIGITS-1:0]   r_scratch;
   logic                  r_sign_cap;
   logic                  r_sign;
   logic [4*DIGITS-1:0]   r_bcd;
   logic                  r_dout_valid;
   logic                  r_dropped;

   logic [WIDTH-1:0]      w_neg;
   logic [WIDTH-1:0]      w_mag_in;
   logic [4*DIGITS-1:0]   w_adj;
   logic [CAT_W-1:0]      w_cat;
   logic [CAT_W-1:0]      w_rot;
   logic                  w_busy;

   assign w_neg    = '0 - din;
   assign w_mag_in = din[WIDTH-1] ? w_neg : din;

   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adjust u_adj (
         .i_digit (r_scratch[4*g +: 4]),
         .o_digit (w_adj[4*g +: 4])
      );
   end

   // Rotate rather than shift: the top adjusted bit is always 0 when
   // 10**DIGITS > 2**(WIDTH-1), and it lands in a mag bit never read again.
   assign w_cat = {w_adj, r_mag};
   assign w_rot = {w_cat[CAT_W-2:0], w_cat[CAT_W-1]};

   // Encoding 2'd3 is treated as IDLE, so it is not busy.
   assign w_busy = (r_state == ST_CONV) || (r_state == ST_DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_iter       <= '0;
         r_mag        <= '0;
         r_scratch    <= '0;
         r_sign_cap   <= 1'b0;
         r_sign       <= 1'b0;
         r_bcd        <= '0;
         r_dout_valid <= 1'b0;
         r_dropped    <= 1'b0;
      end else begin
         r_dout_valid <= 1'b0;
         if (din_valid && w_busy) begin
            r_dropped <= 1'b1;
         end
         case (r_state)
            ST_CONV: begin
               r_scratch <= w_rot[CAT_W-1:WIDTH];
               r_mag     <= w_rot[WIDTH-1:0];
               r_iter    <= r_iter - 1'b1;
               if (r_iter == ITER_W'(1)) begin
                  r_bcd        <= w_rot[CAT_W-1:WIDTH];
                  r_sign       <= r_sign_cap;
                  r_dout_valid <= 1'b1;
                  r_state      <= ST_DONE;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               if (din_valid) begin
                  r_sign_cap <= din[WIDTH-1];
                  r_mag      <= w_mag_in;
                  r_scratch  <= '0;
                  r_iter     <= ITER_W'(WIDTH);
                  r_state    <= ST_CONV;
               end
            end
         endcase
      end
   end

   assign busy       = w_busy;
   assign sign       = r_sign;
   assign bcd        = r_bcd;
   assign dout_valid = r_dout_valid;
   assign dropped    = r_dropped;

endmodule

// File: tb/tb_signed_result_to_bcd.sv
// Scoreboard bench for signed_result_to_bcd: expected sign/BCD and issue cycle
// are queued at capture and checked when dout_valid appears.
module tb_signed_result_to_bcd;

   logic        clk;
   logic        rst;
   logic [7:0]  din;
   logic        din_valid;
   logic        busy;
   logic        sign;
   logic [11:0] bcd;
   logic        dout_valid;
   logic        dropped;

   typedef struct {
      logic [12:0] exp;
      int          cyc;
      logic [7:0]  din;
   } sb_entry_t;

   sb_entry_t sb[$];
   int        cyc;
   int        n_total;
   int        n_bad;

   signed_result_to_bcd #(
      .WIDTH  (8),
      .DIGITS (3)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .din        (din),
      .din_valid  (din_valid),
      .busy       (busy),
      .sign       (sign),
      .bcd        (bcd),
      .dout_valid (dout_valid),
      .dropped    (dropped)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [12:0] ref_res(input logic [7:0] v);
      int s;
      int m;
      s = int'($signed(v));
      m = (s < 0) ? -s : s;
      return {((s < 0) ? 1'b1 : 1'b0), 4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
   endfunction

   always @(negedge clk) begin
      if (dout_valid) begin
         if (sb.size() == 0) begin
            check("spurious_valid", 32'(dout_valid), 32'd0);
         end else begin
            sb_entry_t e;
            e = sb.pop_front();
            check($sformatf("sign_%02h", e.din), 32'(sign), 32'(e.exp[12]));
            check($sformatf("bcd_%02h", e.din), 32'(bcd), 32'(e.exp[11:0]));
            check($sformatf("latency_%02h", e.din), 32'(cyc - e.cyc), 32'd9);
         end
      end
   end

   task automatic pulse(input logic [7:0] v, input bit track);
      @(negedge clk);
      din       = v;
      din_valid = 1'b1;
      if (track) sb.push_back('{exp: ref_res(v), cyc: cyc, din: v});
      @(negedge clk);
      din_valid = 1'b0;
      din       = 8'($urandom);
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
      check("drain_timeout", 32'(sb.size()), 32'd0);
      @(negedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"},  32'(busy),       32'd0);
      check({tag, "_sign"},  32'(sign),       32'd0);
      check({tag, "_bcd"},   32'(bcd),        32'd0);
      check({tag, "_dv"},    32'(dout_valid), 32'd0);
      check({tag, "_drop"},  32'(dropped),    32'd0);
   endtask

   initial begin
      logic [7:0] directed [5];
      n_total   = 0;
      n_bad     = 0;
      rst       = 1'b1;
      din       = 8'h00;
      din_valid = 1'b0;
      directed  = '{8'd127, 8'd99, 8'h80, 8'hF9, 8'hFF};

      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;

      pulse(8'd0, 1'b1);
      check("busy_cycle1", 32'(busy), 32'd1);
      drain();
      check("busy_after_done", 32'(busy), 32'd0);

      foreach (directed[i]) begin
         pulse(directed[i], 1'b1);
         drain();
      end

      // last result must hold while din wanders and nothing is captured
      repeat (5) begin
         @(negedge clk);
         din = 8'($urandom);
      end
      check("hold_sign", 32'(sign), 32'd1);
      check("hold_bcd",  32'(bcd),  32'h001);
      check("no_drop_yet", 32'(dropped), 32'd0);

      pulse(8'd55, 1'b1);
      repeat (2) @(negedge clk);
      pulse(8'd77, 1'b0);
      check("dropped_set", 32'(dropped), 32'd1);
      drain();
      repeat (15) @(negedge clk);
      check("dropped_sticky", 32'(dropped), 32'd1);

      pulse(8'd100, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_all_zero("midconv_rst");
      rst = 1'b0;
      repeat (12) @(negedge clk);
      pulse(8'd42, 1'b1);
      drain();

      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int v = 0; v < 256; v++) begin
         pulse(8'(v), 1'b1);
         repeat (8) @(negedge clk);
      end
      drain();
      check("sweep_no_drop", 32'(dropped), 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
